// File: rtl/clk_div_monitor_if.sv
// Monitor-side signal bundle for clk_div_monitor.
// master: drives the divided clock, expected ratio, enable and error clear
//         (the divider / control side, or a testbench).
// slave : the monitor; returns the measured period and high time, a
//         measurement strobe, and the lock / bypass / error / timeout flags.
// The reference clock and reset are plain ports on the monitor itself.
interface clk_div_monitor_if #(
  parameter int RATIO_WIDTH = 8,
  parameter int CNT_WIDTH   = 9
);
  logic                   I_DIV_CLK;
  logic [RATIO_WIDTH-1:0] I_EXP_RATIO;
  logic                   I_MON_EN;
  logic                   I_ERR_CLR;
  logic [CNT_WIDTH-1:0]   O_PERIOD;
  logic [CNT_WIDTH-1:0]   O_HIGH_CNT;
  logic                   O_MEAS_VLD;
  logic                   O_LOCK;
  logic                   O_BYPASS;
  logic                   O_ERR;
  logic                   O_TIMEOUT;

  modport master (
    output I_DIV_CLK, I_EXP_RATIO, I_MON_EN, I_ERR_CLR,
    input  O_PERIOD, O_HIGH_CNT, O_MEAS_VLD, O_LOCK, O_BYPASS, O_ERR, O_TIMEOUT
  );

  modport slave (
    input  I_DIV_CLK, I_EXP_RATIO, I_MON_EN, I_ERR_CLR,
    output O_PERIOD, O_HIGH_CNT, O_MEAS_VLD, O_LOCK, O_BYPASS, O_ERR, O_TIMEOUT
  );
endinterface

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: checks a divided clock against its programmed ratio.
// Runs on the reference clock and treats the divided clock as data. Each
// divided-clock period and its high time are measured in reference cycles
// and compared with the expected ratio; the result is reported as lock,
// a sticky mismatch error and a sticky stall timeout.
// Ports:
//   I_REF_CLK : reference clock (also clocks the divider)
//   RST_EN    : asynchronous active-low reset
//   mon       : clk_div_monitor_if.slave
//     I_DIV_CLK, I_EXP_RATIO, I_MON_EN, I_ERR_CLR      (inputs)
//     O_PERIOD, O_HIGH_CNT, O_MEAS_VLD, O_LOCK,
//     O_BYPASS, O_ERR, O_TIMEOUT                       (registered outputs)
module clk_div_monitor #(
  parameter int RATIO_WIDTH = 8,
  parameter int CNT_WIDTH   = 9,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             I_REF_CLK,
  input  logic             RST_EN,
  clk_div_monitor_if.slave mon
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [MC_W-1:0]      LOCK_VAL = MC_W'(LOCK_COUNT);

  typedef enum logic [2:0] {IDLE, ARM, SKIP, MEAS, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic                   div_q, div_d;
  logic [RATIO_WIDTH-1:0] ratio_q, ratio_d;
  logic [CNT_WIDTH-1:0]   per_cnt_q, per_cnt_d;
  logic [CNT_WIDTH-1:0]   high_cnt_q, high_cnt_d;
  logic [MC_W-1:0]        match_cnt_q, match_cnt_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  logic [CNT_WIDTH-1:0]   high_q, high_d;
  logic                   meas_vld_q, meas_vld_d;
  logic                   lock_q, lock_d;
  logic                   bypass_q, bypass_d;
  logic                   err_q, err_d;
  logic                   timeout_q, timeout_d;

  logic                   rise;
  logic                   is_bypass;
  logic                   err_set;
  logic                   timeout_set;
  logic [MC_W-1:0]        match_inc;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // A period matches when it equals R exactly and the high time is either
  // half of R rounded down or rounded up (odd ratios have no exact half).
  function automatic logic is_match(input logic [CNT_WIDTH-1:0] per,
                                    input logic [CNT_WIDTH-1:0] high,
                                    input logic [CNT_WIDTH-1:0] r);
    logic [CNT_WIDTH-1:0] half_lo;
    logic [CNT_WIDTH-1:0] half_hi;
    half_lo = r >> 1;
    half_hi = (r + 1'b1) >> 1;
    return (per == r) && ((high == half_lo) || (high == half_hi));
  endfunction

  always_comb begin
    rise        = mon.I_DIV_CLK & ~div_q;
    is_bypass   = mon.I_EXP_RATIO < RATIO_WIDTH'(2);
    match_inc   = match_cnt_q + 1'b1;

    state_d     = state_q;
    div_d       = mon.I_DIV_CLK;
    ratio_d     = mon.I_EXP_RATIO;
    match_cnt_d = match_cnt_q;
    period_d    = period_q;
    high_d      = high_q;
    meas_vld_d  = 1'b0;
    lock_d      = lock_q;
    bypass_d    = is_bypass;
    err_set     = 1'b0;
    timeout_set = 1'b0;

    if (rise) begin
      per_cnt_d  = CNT_WIDTH'(1);
      high_cnt_d = CNT_WIDTH'(1);
    end else begin
      per_cnt_d  = sat_inc(per_cnt_q);
      high_cnt_d = mon.I_DIV_CLK ? sat_inc(high_cnt_q) : high_cnt_q;
    end

    if (state_q == IDLE) begin
      per_cnt_d   = '0;
      high_cnt_d  = '0;
      match_cnt_d = '0;
      lock_d      = 1'b0;
      if (mon.I_MON_EN && !is_bypass) state_d = ARM;
    end else if (!mon.I_MON_EN || is_bypass) begin
      state_d     = IDLE;
      per_cnt_d   = '0;
      high_cnt_d  = '0;
      match_cnt_d = '0;
      lock_d      = 1'b0;
    end else if (mon.I_EXP_RATIO != ratio_q) begin
      // Reprogramming the divider is expected, not an error: just re-acquire.
      state_d     = ARM;
      match_cnt_d = '0;
      lock_d      = 1'b0;
    end else if (per_cnt_q == CNT_MAX) begin
      // Restart the counters so the next stall window starts from zero
      // rather than re-triggering on a counter that stays pinned.
      timeout_set = 1'b1;
      state_d     = ARM;
      per_cnt_d   = '0;
      high_cnt_d  = '0;
      match_cnt_d = '0;
      lock_d      = 1'b0;
    end else if (rise) begin
      unique case (state_q)
        ARM: state_d = SKIP;
        SKIP: begin
          // The first full period after arming is captured but not judged.
          period_d    = per_cnt_q;
          high_d      = high_cnt_q;
          meas_vld_d  = 1'b1;
          match_cnt_d = '0;
          state_d     = MEAS;
        end
        MEAS, LOCKED: begin
          period_d   = per_cnt_q;
          high_d     = high_cnt_q;
          meas_vld_d = 1'b1;
          if (is_match(per_cnt_q, high_cnt_q, CNT_WIDTH'(mon.I_EXP_RATIO))) begin
            if (state_q == MEAS) begin
              match_cnt_d = match_inc;
              if (match_inc == LOCK_VAL) begin
                state_d = LOCKED;
                lock_d  = 1'b1;
              end
            end
          end else begin
            err_set     = 1'b1;
            lock_d      = 1'b0;
            match_cnt_d = '0;
            state_d     = MEAS;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A new event in the same cycle as a clear request keeps the flag set.
    err_d     = err_set     | (err_q     & ~mon.I_ERR_CLR);
    timeout_d = timeout_set | (timeout_q & ~mon.I_ERR_CLR);
  end

  always_ff @(posedge I_REF_CLK or negedge RST_EN) begin
    if (!RST_EN) begin
      state_q     <= IDLE;
      div_q       <= 1'b0;
      ratio_q     <= '0;
      per_cnt_q   <= '0;
      high_cnt_q  <= '0;
      match_cnt_q <= '0;
      period_q    <= '0;
      high_q      <= '0;
      meas_vld_q  <= 1'b0;
      lock_q      <= 1'b0;
      bypass_q    <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      ratio_q     <= ratio_d;
      per_cnt_q   <= per_cnt_d;
      high_cnt_q  <= high_cnt_d;
      match_cnt_q <= match_cnt_d;
      period_q    <= period_d;
      high_q      <= high_d;
      meas_vld_q  <= meas_vld_d;
      lock_q      <= lock_d;
      bypass_q    <= bypass_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign mon.O_PERIOD   = period_q;
  assign mon.O_HIGH_CNT = high_q;
  assign mon.O_MEAS_VLD = meas_vld_q;
  assign mon.O_LOCK     = lock_q;
  assign mon.O_BYPASS   = bypass_q;
  assign mon.O_ERR      = err_q;
  assign mon.O_TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Testbench for clk_div_monitor: directed scenarios driven from one
// stimulus process, a timestamp-based reference model checked every cycle,
// and literal expectations at the key points of each scenario.
module tb_clk_div_monitor;

  localparam int RW   = 8;
  localparam int CW   = 9;
  localparam int LC   = 4;
  localparam int MAXC = (1 << CW) - 1;
  localparam int HSZ  = 1024;

  logic clk;
  logic rst_n;

  clk_div_monitor_if #(.RATIO_WIDTH(RW), .CNT_WIDTH(CW)) bus ();

  clk_div_monitor #(.RATIO_WIDTH(RW), .CNT_WIDTH(CW), .LOCK_COUNT(LC)) dut (
    .I_REF_CLK (clk),
    .RST_EN    (rst_n),
    .mon       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Period and high time are derived from cycle timestamps: 'base' is the
  // cycle a measurement window started, and the high time is the number of
  // sampled-high cycles in the window (taken from a history buffer).
  localparam int M_OFF = 0, M_WAIT1 = 1, M_WAIT2 = 2, M_RUN = 3;
  int cyc = 0;
  int base = 1;
  int mode = M_OFF;
  int streak = 0;
  int rprev = 0;
  bit dprev = 0;
  bit hist [0:HSZ-1];
  int e_per = 0, e_high = 0;
  bit e_vld = 0, e_lock = 0, e_byp = 0, e_err = 0, e_to = 0;

  task automatic m_reset();
    mode = M_OFF; streak = 0; rprev = 0; dprev = 0;
    e_per = 0; e_high = 0; e_vld = 0; e_lock = 0; e_byp = 0; e_err = 0; e_to = 0;
    base = cyc + 1;
    cyc++;
  endtask

  task automatic m_step();
    int r, per, high, nbase;
    bit en, d, clr, rise, good, restart, eset, tset;
    r = int'(bus.I_EXP_RATIO); en = bus.I_MON_EN; d = bus.I_DIV_CLK; clr = bus.I_ERR_CLR;
    hist[cyc % HSZ] = d;
    per = cyc - base;
    if (per > MAXC) per = MAXC;
    high = 0;
    for (int k = base; k < cyc; k++) high += int'(hist[k % HSZ]);
    if (high > MAXC) high = MAXC;
    rise = d && !dprev;
    e_vld = 0; eset = 0; tset = 0; restart = 0;
    nbase = rise ? cyc : base;
    if (mode == M_OFF) begin
      e_lock = 0; restart = 1; streak = 0;
      if (en && r >= 2) mode = M_WAIT1;
    end else if (!en || r < 2) begin
      mode = M_OFF; e_lock = 0; restart = 1;
    end else if (r != rprev) begin
      mode = M_WAIT1; e_lock = 0; streak = 0;
    end else if (per == MAXC) begin
      tset = 1; e_lock = 0; mode = M_WAIT1; streak = 0; restart = 1;
    end else if (rise) begin
      if (mode == M_WAIT1) mode = M_WAIT2;
      else begin
        e_per = per; e_high = high; e_vld = 1;
        if (mode == M_WAIT2) begin
          mode = M_RUN; streak = 0;
        end else begin
          good = (per == r) && (high == r / 2 || high == (r + 1) / 2);
          if (good) begin
            if (!e_lock) begin
              streak++;
              if (streak >= LC) e_lock = 1;
            end
          end else begin
            eset = 1; e_lock = 0; streak = 0;
          end
        end
      end
    end
    base  = restart ? cyc + 1 : nbase;
    e_byp = (r < 2);
    e_err = eset | (e_err & !clr);
    e_to  = tset | (e_to & !clr);
    rprev = r; dprev = d;
    cyc++;
  endtask

  always @(posedge clk) begin
    if (!rst_n) m_reset();
    else        m_step();
    #1;
    check("period",   int'(bus.O_PERIOD),   e_per);
    check("high_cnt", int'(bus.O_HIGH_CNT), e_high);
    check("meas_vld", int'(bus.O_MEAS_VLD), int'(e_vld));
    check("lock",     int'(bus.O_LOCK),     int'(e_lock));
    check("bypass",   int'(bus.O_BYPASS),   int'(e_byp));
    check("err",      int'(bus.O_ERR),      int'(e_err));
    check("timeout",  int'(bus.O_TIMEOUT),  int'(e_to));
  end

  // ---------------- stimulus ----------------
  int div_n = 0;
  int div_ph = 0;
  bit any_lock = 0;

  task automatic step();
    @(negedge clk);
    if (div_n == 0) bus.I_DIV_CLK = 1'b0;
    else begin
      bus.I_DIV_CLK = (div_ph < (div_n + 1) / 2);
      div_ph = (div_ph + 1) % div_n;
    end
    if (bus.O_LOCK) any_lock = 1;
  endtask

  task automatic set_div(input int n);
    div_n = n; div_ph = 0;
  endtask

  task automatic wait_lock(input int lim, output int vlds, output bit seen);
    vlds = 0; seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      step();
      if (bus.O_MEAS_VLD) vlds++;
      if (bus.O_LOCK) seen = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int vlds, steps;
    bit seen;
    rst_n = 1'b0;
    bus.I_DIV_CLK = 1'b0; bus.I_EXP_RATIO = '0; bus.I_MON_EN = 1'b0; bus.I_ERR_CLR = 1'b0;
    repeat (3) step();
    check("rst_period", int'(bus.O_PERIOD), 0);
    check("rst_lock",   int'(bus.O_LOCK),   0);
    check("rst_err",    int'(bus.O_ERR),    0);

    // 1: ratio 2 with matching divider
    rst_n = 1'b1; bus.I_MON_EN = 1'b1; bus.I_EXP_RATIO = 8'd2; set_div(2);
    wait_lock(60, vlds, seen);
    check("t1_locked", int'(seen), 1);
    check("t1_vld_before_lock", vlds, LC + 1);
    repeat (10) step();
    check("t1_period", int'(bus.O_PERIOD),   2);
    check("t1_high",   int'(bus.O_HIGH_CNT), 1);
    check("t1_lock",   int'(bus.O_LOCK),     1);
    check("t1_err",    int'(bus.O_ERR),      0);

    // 2: ratio 5
    bus.I_EXP_RATIO = 8'd5; set_div(5);
    wait_lock(100, vlds, seen);
    check("t2_locked", int'(seen), 1);
    repeat (12) step();
    check("t2_period", int'(bus.O_PERIOD), 5);
    check("t2_high_ok", int'(bus.O_HIGH_CNT == 2 || bus.O_HIGH_CNT == 3), 1);
    check("t2_err", int'(bus.O_ERR), 0);

    // 3: locked at 3, reprogram to 4
    bus.I_EXP_RATIO = 8'd3; set_div(3);
    wait_lock(80, vlds, seen);
    check("t3_locked3", int'(seen), 1);
    bus.I_EXP_RATIO = 8'd4; set_div(4);
    step();
    check("t3_lock_drop", int'(bus.O_LOCK), 0);
    wait_lock(100, vlds, seen);
    check("t3_relock", int'(seen), 1);
    check("t3_period", int'(bus.O_PERIOD),   4);
    check("t3_high",   int'(bus.O_HIGH_CNT), 2);
    check("t3_err",    int'(bus.O_ERR),      0);

    // 4: divide-by-3 while expecting 4
    bus.I_MON_EN = 1'b0; set_div(3);
    step(); step();
    any_lock = 0;
    bus.I_MON_EN = 1'b1;
    vlds = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (bus.O_MEAS_VLD) vlds++;
      if (bus.O_ERR) seen = 1;
    end
    check("t4_err_set", int'(seen), 1);
    check("t4_vld_at_err", vlds, 2);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (bus.O_MEAS_VLD) seen = 1;
    end
    check("t4_vld_seen", int'(seen), 1);
    bus.I_ERR_CLR = 1'b1; step(); bus.I_ERR_CLR = 1'b0;
    check("t4_err_cleared", int'(bus.O_ERR), 0);
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step();
      if (bus.O_ERR) seen = 1;
    end
    check("t4_err_again", int'(seen), 1);
    step(); step();
    bus.I_ERR_CLR = 1'b1; step(); bus.I_ERR_CLR = 1'b0;
    check("t4_set_wins", int'(bus.O_ERR), 1);
    check("t4_never_locked", int'(any_lock), 0);

    // 5: bypass ratios
    bus.I_EXP_RATIO = 8'd0;
    step();
    bus.I_ERR_CLR = 1'b1; step(); bus.I_ERR_CLR = 1'b0;
    vlds = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.O_MEAS_VLD) vlds++;
    end
    check("t5_r0_bypass", int'(bus.O_BYPASS), 1);
    check("t5_r0_vld", vlds, 0);
    check("t5_err", int'(bus.O_ERR), 0);
    check("t5_timeout", int'(bus.O_TIMEOUT), 0);
    bus.I_EXP_RATIO = 8'd1;
    vlds = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.O_MEAS_VLD) vlds++;
    end
    check("t5_r1_bypass", int'(bus.O_BYPASS), 1);
    check("t5_r1_vld", vlds, 0);

    // 6: stall while locked, then reset mid-lock
    bus.I_EXP_RATIO = 8'd2; set_div(2);
    wait_lock(60, vlds, seen);
    check("t6_locked", int'(seen), 1);
    check("t6_bypass_off", int'(bus.O_BYPASS), 0);
    set_div(0);
    steps = 0; seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      step();
      steps++;
      if (i == 499) check("t6_no_early_timeout", int'(bus.O_TIMEOUT), 0);
      if (bus.O_TIMEOUT) seen = 1;
    end
    check("t6_timeout", int'(seen), 1);
    check("t6_timeout_window", int'(steps >= 505 && steps <= 515), 1);
    check("t6_lock_cleared", int'(bus.O_LOCK), 0);
    set_div(2);
    wait_lock(60, vlds, seen);
    check("t6_relocked", int'(seen), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_period",  int'(bus.O_PERIOD),   0);
    check("t6_rst_high",    int'(bus.O_HIGH_CNT), 0);
    check("t6_rst_vld",     int'(bus.O_MEAS_VLD), 0);
    check("t6_rst_lock",    int'(bus.O_LOCK),     0);
    check("t6_rst_bypass",  int'(bus.O_BYPASS),   0);
    check("t6_rst_err",     int'(bus.O_ERR),      0);
    check("t6_rst_timeout", int'(bus.O_TIMEOUT),  0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
